pid_ctrl_param: RTL and testbench
=================================

// Module: pid_ctrl_param
// PURPOSE
//  Parametrised, runtime-tunable successor to the fixed-constant PID loop block.
//  Per start request: samples setpoint, measurement and gains; computes signed error and
//  positional PID (P + clamped integrator + D); rounds by fixed-point shift; saturates to an
//  output range. Sits between the sensor-sample interface and the actuator/DAC register.
//  One shared multiplier, sequenced by an FSM, with a start/busy/done handshake.
// PARAMETERS
//  DW     16               measurement/setpoint/output width (unsigned)
//  GW     16               gain width, unsigned Q(GW-FRAC).FRAC
//  FRAC   8                gain fraction bits; final sum is shifted right by FRAC
//  ACCW   48               internal signed accumulator width (>= GW+DW+4)
//  I_LIM  2**(DW+FRAC)-1   integrator magnitude limit, in accumulator units
//  OUT_MIN 0 / OUT_MAX 2**DW-1   output saturation bounds
// PORTS
//  clk       in   1    clock, rising edge
//  rst       in   1    asynchronous reset, active-high
//  start     in   1    request one PID step; sampled only in IDLE
//  clear     in   1    zero integrator and previous error; honoured only in IDLE
//  setpoint  in   DW   target value
//  data_in   in   DW   measured value
//  kp,ki,kd  in   GW   gains (Q format per FRAC)
//  busy      out  1    high while a step is in progress
//  done      out  1    one-cycle pulse: data_out updated
//  data_out  out  DW   saturated controller output (held between steps)
//  sat_hi    out  1    last output clamped to OUT_MAX
//  sat_lo    out  1    last output clamped to OUT_MIN
// BEHAVIOUR
//  Reset (async): state=IDLE; data_out, busy, done, sat_hi, sat_lo, integ, e_prev = 0.
//  FSM: IDLE -> ERR -> MUL_P -> MUL_I -> MUL_D -> SUM -> SAT -> IDLE.
//  - IDLE: if start, register setpoint/data_in/gains, busy<=1. If clear, integ=0 and e_prev=0
//    first; clear+start in the same cycle runs the step from the cleared state.
//  - ERR:   e = sp - din, signed DW+1 bits; de = e - e_prev, signed DW+2 bits.
//  - MUL_P: p = kp*e (signed ACCW).
//  - MUL_I: integ = clamp(integ + ki*e, -I_LIM, +I_LIM).
//  - MUL_D: d = kd*de.
//  - SUM:   s = (p + integ + d) >>> FRAC (arithmetic shift, floor).
//  - SAT:   data_out = clamp(s, OUT_MIN, OUT_MAX); set sat_hi/sat_lo; e_prev<=e;
//           done<=1 for one cycle; busy<=0.
//  Latency: start sampled at edge N -> data_out/done registered at edge N+6. busy is high
//    edges N..N+5 and low when done is high. Back-to-back start at the done cycle is accepted.
//  start while busy: ignored (no queueing). clear while busy: ignored.
//  Inputs/gains change while busy: no effect on the current step.
//  rst mid-step: abort immediately; no done pulse; all state returns to reset values.
//  No internal overflow for legal parameters: the ACCW check is an elaboration-time error.
// CONFIGURATION
//  PID_ANTIWINDUP_EN defined: conditional integration. MUL_I skips the integ update when the
//    previous step saturated (sat_hi with ki*e>0, or sat_lo with ki*e<0); the I_LIM clamp still
//    applies. Undefined: integ always updates, bounded only by the I_LIM clamp.
// TESTING  (DW=16, GW=16, FRAC=8; gain 0x0100 = 1.0)
//  1 Assert rst mid-run, release -> data_out=0, busy=0, done=0, sat_hi=sat_lo=0, no done pulse.
//  2 kp=0x0100, ki=kd=0, sp=1000, din=400 -> data_out=600 with done exactly 6 cycles after start.
//  3 kp=0x0A00, sp=60000, din=0 -> data_out=65535, sat_hi=1; then kp=0x0100, sp=0, din=500
//    -> data_out=0, sat_lo=1.
//  4 ki=0x0080, kp=kd=0, sp=110, din=100, three steps -> 5, 10, 15; clear then one step -> 5.
//  5 kd=0x0100, kp=ki=0, sp=100, din=0, two steps -> 100 then 0; start pulsed while busy is
//    ignored (exactly one done pulse per accepted start).
//  6 PID_ANTIWINDUP_EN: kp=0x0A00, ki=0x0100, sp=60000, din=0, 4 steps saturating, then
//    sp=din -> integ frozen after step 1; with the macro undefined, integ grows each step.

Source files
------------

// File: rtl/pid_ctrl_param.sv
// pid_ctrl_param: runtime-tunable positional PID step engine.
//
// Each accepted start registers setpoint, measurement and gains. The step then
// computes the error and its change, forms P, the clamped integrator and D on
// one shared multiplier, rounds the sum down by FRAC bits and saturates it to
// [OUT_MIN, OUT_MAX].
//
// Optional build macro:
//   PID_ANTIWINDUP_EN  conditional integration. The integrator is frozen while
//                      the previous output was saturated in the direction the
//                      new ki*e term would push it.
//
// Ports:
//   clk       in   1    clock, rising edge
//   rst       in   1    asynchronous reset, active-high
//   start     in   1    request one PID step (sampled only in IDLE)
//   clear     in   1    zero integrator and previous error (only in IDLE)
//   setpoint  in   DW   target value
//   data_in   in   DW   measured value
//   kp/ki/kd  in   GW   unsigned gains, FRAC fraction bits
//   busy      out  1    step in progress
//   done      out  1    one-cycle pulse, data_out updated
//   data_out  out  DW   saturated controller output
//   sat_hi    out  1    last output clamped to OUT_MAX
//   sat_lo    out  1    last output clamped to OUT_MIN
module pid_ctrl_param #(
    parameter int unsigned DW      = 16,
    parameter int unsigned GW      = 16,
    parameter int unsigned FRAC    = 8,
    parameter int unsigned ACCW    = 48,
    parameter longint      I_LIM   = (longint'(1) <<< (DW + FRAC)) - longint'(1),
    parameter longint      OUT_MIN = 0,
    parameter longint      OUT_MAX = (longint'(1) <<< DW) - longint'(1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          clear,
    input  logic [DW-1:0] setpoint,
    input  logic [DW-1:0] data_in,
    input  logic [GW-1:0] kp,
    input  logic [GW-1:0] ki,
    input  logic [GW-1:0] kd,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] data_out,
    output logic          sat_hi,
    output logic          sat_lo
);

    localparam int unsigned EW = DW + 1;
    localparam int unsigned DEW = DW + 2;

    localparam logic signed [ACCW-1:0] ZERO_A    = '0;
    localparam logic signed [ACCW-1:0] I_LIM_P   = ACCW'(I_LIM);
    localparam logic signed [ACCW-1:0] I_LIM_N   = ACCW'(-I_LIM);
    localparam logic signed [ACCW-1:0] OUT_MIN_A = ACCW'(OUT_MIN);
    localparam logic signed [ACCW-1:0] OUT_MAX_A = ACCW'(OUT_MAX);

    // Accumulator must hold gain*error plus headroom for the three-term sum.
    generate
        if (ACCW < GW + DW + 4) begin : g_accw_check
            $error("pid_ctrl_param: ACCW must be >= GW+DW+4");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERR,
        S_MUL_P,
        S_MUL_I,
        S_MUL_D,
        S_SUM,
        S_SAT
    } state_e;

    state_e state_q, state_d;

    logic [DW-1:0]          sp_q, sp_d;
    logic [DW-1:0]          din_q, din_d;
    logic [GW-1:0]          kp_q, kp_d;
    logic [GW-1:0]          ki_q, ki_d;
    logic [GW-1:0]          kd_q, kd_d;
    logic signed [EW-1:0]   e_q, e_d;
    logic signed [EW-1:0]   e_prev_q, e_prev_d;
    logic signed [DEW-1:0]  de_q, de_d;
    logic signed [ACCW-1:0] p_q, p_d;
    logic signed [ACCW-1:0] integ_q, integ_d;
    logic signed [ACCW-1:0] d_q, d_d;
    logic signed [ACCW-1:0] sum_q, sum_d;
    logic [DW-1:0]          data_out_q, data_out_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   sat_hi_q, sat_hi_d;
    logic                   sat_lo_q, sat_lo_d;

    // Shared multiplier: unsigned gain (zero-extended) times signed operand.
    logic signed [ACCW-1:0] mul_a, mul_b, prod;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            S_MUL_P: begin
                mul_a = ACCW'(kp_q);
                mul_b = ACCW'(e_q);
            end
            S_MUL_I: begin
                mul_a = ACCW'(ki_q);
                mul_b = ACCW'(e_q);
            end
            S_MUL_D: begin
                mul_a = ACCW'(kd_q);
                mul_b = ACCW'(de_q);
            end
            default: ;
        endcase
        prod = mul_a * mul_b;
    end

    // Integrator freeze condition for conditional integration.
    logic hold_i;

    always_comb begin
`ifdef PID_ANTIWINDUP_EN
        hold_i = (sat_hi_q && (prod > ZERO_A)) || (sat_lo_q && (prod < ZERO_A));
`else
        hold_i = 1'b0;
`endif
    end

    // Next-state and datapath sequencing.
    logic signed [ACCW-1:0] i_sum;
    logic signed [EW-1:0]   e_n;

    always_comb begin
        state_d    = state_q;
        sp_d       = sp_q;
        din_d      = din_q;
        kp_d       = kp_q;
        ki_d       = ki_q;
        kd_d       = kd_q;
        e_d        = e_q;
        e_prev_d   = e_prev_q;
        de_d       = de_q;
        p_d        = p_q;
        integ_d    = integ_q;
        d_d        = d_q;
        sum_d      = sum_q;
        data_out_d = data_out_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sat_hi_d   = sat_hi_q;
        sat_lo_d   = sat_lo_q;
        i_sum      = integ_q + prod;
        e_n        = $signed({1'b0, sp_q}) - $signed({1'b0, din_q});

        case (state_q)
            S_IDLE: begin
                // Clear takes effect before a same-cycle start is processed.
                if (clear) begin
                    integ_d  = '0;
                    e_prev_d = '0;
                end
                if (start) begin
                    sp_d    = setpoint;
                    din_d   = data_in;
                    kp_d    = kp;
                    ki_d    = ki;
                    kd_d    = kd;
                    busy_d  = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_ERR: begin
                e_d     = e_n;
                de_d    = $signed({e_n[EW-1], e_n}) - $signed({e_prev_q[EW-1], e_prev_q});
                state_d = S_MUL_P;
            end
            S_MUL_P: begin
                p_d     = prod;
                state_d = S_MUL_I;
            end
            S_MUL_I: begin
                if (!hold_i) begin
                    if (i_sum > I_LIM_P) begin
                        integ_d = I_LIM_P;
                    end else if (i_sum < I_LIM_N) begin
                        integ_d = I_LIM_N;
                    end else begin
                        integ_d = i_sum;
                    end
                end
                state_d = S_MUL_D;
            end
            S_MUL_D: begin
                d_d     = prod;
                state_d = S_SUM;
            end
            S_SUM: begin
                sum_d   = (p_q + integ_q + d_q) >>> FRAC;
                state_d = S_SAT;
            end
            S_SAT: begin
                sat_hi_d = 1'b0;
                sat_lo_d = 1'b0;
                if (sum_q > OUT_MAX_A) begin
                    data_out_d = DW'(OUT_MAX_A);
                    sat_hi_d   = 1'b1;
                end else if (sum_q < OUT_MIN_A) begin
                    data_out_d = DW'(OUT_MIN_A);
                    sat_lo_d   = 1'b1;
                end else begin
                    data_out_d = DW'(sum_q);
                end
                e_prev_d = e_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sp_q       <= '0;
            din_q      <= '0;
            kp_q       <= '0;
            ki_q       <= '0;
            kd_q       <= '0;
            e_q        <= '0;
            e_prev_q   <= '0;
            de_q       <= '0;
            p_q        <= '0;
            integ_q    <= '0;
            d_q        <= '0;
            sum_q      <= '0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sat_hi_q   <= 1'b0;
            sat_lo_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sp_q       <= sp_d;
            din_q      <= din_d;
            kp_q       <= kp_d;
            ki_q       <= ki_d;
            kd_q       <= kd_d;
            e_q        <= e_d;
            e_prev_q   <= e_prev_d;
            de_q       <= de_d;
            p_q        <= p_d;
            integ_q    <= integ_d;
            d_q        <= d_d;
            sum_q      <= sum_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sat_hi_q   <= sat_hi_d;
            sat_lo_q   <= sat_lo_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = data_out_q;
    assign sat_hi   = sat_hi_q;
    assign sat_lo   = sat_lo_q;

endmodule

// File: tb/tb_pid_ctrl_param.sv
// tb_pid_ctrl_param: directed self-checking bench for pid_ctrl_param
// (DW=16, GW=16, FRAC=8; gain 0x0100 = 1.0). Expected values are hand-computed.
module tb_pid_ctrl_param;

    logic        clk;
    logic        rst;
    logic        start;
    logic        clear;
    logic [15:0] setpoint;
    logic [15:0] data_in;
    logic [15:0] kp;
    logic [15:0] ki;
    logic [15:0] kd;
    logic        busy;
    logic        done;
    logic [15:0] data_out;
    logic        sat_hi;
    logic        sat_lo;

    int n_checks;
    int n_fail;

    pid_ctrl_param dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .clear    (clear),
        .setpoint (setpoint),
        .data_in  (data_in),
        .kp       (kp),
        .ki       (ki),
        .kd       (kd),
        .busy     (busy),
        .done     (done),
        .data_out (data_out),
        .sat_hi   (sat_hi),
        .sat_lo   (sat_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One step from a negedge: pulse start (optionally with clear), then wait
    // for done with a bounded loop. Optionally pulses a stray start mid-step.
    task automatic run_step(input logic clr, input logic stray, input string name);
        int lat;
        start = 1'b1;
        clear = clr;
        @(negedge clk);
        start = 1'b0;
        clear = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_after_start: got %b want 1", name, busy);
        end
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            if (stray && k == 2) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        n_checks++;
        if (lat != 6) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want 6", name, lat);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_at_done: got %b want 0", name, busy);
        end
    endtask

    task automatic check_out(input string name, input logic [15:0] exp_d,
                             input logic exp_hi, input logic exp_lo);
        n_checks++;
        if (data_out !== exp_d || sat_hi !== exp_hi || sat_lo !== exp_lo) begin
            n_fail++;
            $display("FAIL %s: got data_out=%0d sat_hi=%b sat_lo=%b want %0d %b %b",
                     name, data_out, sat_hi, sat_lo, exp_d, exp_hi, exp_lo);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (data_out !== 16'd0 || busy !== 1'b0 || done !== 1'b0 ||
            sat_hi !== 1'b0 || sat_lo !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got d=%0d b=%b dn=%b hi=%b lo=%b want all 0",
                     data_out, busy, done, sat_hi, sat_lo);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_proportional;
        kp = 16'h0100; ki = 16'h0000; kd = 16'h0000;
        setpoint = 16'd1000; data_in = 16'd400;
        run_step(1'b1, 1'b0, "prop");
        check_out("prop_out", 16'd600, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid;
        int dones;
        kp = 16'h0100; setpoint = 16'd3000; data_in = 16'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (data_out !== 16'd0 || busy !== 1'b0 || done !== 1'b0 ||
            sat_hi !== 1'b0 || sat_lo !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_state: got d=%0d b=%b dn=%b hi=%b lo=%b want all 0",
                     data_out, busy, done, sat_hi, sat_lo);
        end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        n_checks++;
        if (dones != 0 || data_out !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid_abort: got activity=%0d data_out=%0d want 0 0",
                     dones, data_out);
        end
    endtask

    task automatic test_saturation;
        kp = 16'h0A00; ki = 16'h0000; kd = 16'h0000;
        setpoint = 16'd60000; data_in = 16'd0;
        run_step(1'b1, 1'b0, "sat_hi");
        check_out("sat_hi_out", 16'd65535, 1'b1, 1'b0);
        kp = 16'h0100; setpoint = 16'd0; data_in = 16'd500;
        run_step(1'b0, 1'b0, "sat_lo");
        check_out("sat_lo_out", 16'd0, 1'b0, 1'b1);
    endtask

    // Consecutive steps start on the done cycle (back-to-back acceptance).
    task automatic test_integral;
        logic [15:0] exp_v [3];
        exp_v[0] = 16'd5; exp_v[1] = 16'd10; exp_v[2] = 16'd15;
        kp = 16'h0000; ki = 16'h0080; kd = 16'h0000;
        setpoint = 16'd110; data_in = 16'd100;
        for (int i = 0; i < 3; i++) begin
            run_step(i == 0, 1'b0, "integ");
            check_out($sformatf("integ_step%0d", i), exp_v[i], 1'b0, 1'b0);
        end
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        run_step(1'b0, 1'b0, "integ_clr");
        check_out("integ_after_clear", 16'd5, 1'b0, 1'b0);
    endtask

    task automatic test_derivative;
        int extra;
        kp = 16'h0000; ki = 16'h0000; kd = 16'h0100;
        setpoint = 16'd100; data_in = 16'd0;
        run_step(1'b1, 1'b0, "deriv1");
        check_out("deriv_step1", 16'd100, 1'b0, 1'b0);
        run_step(1'b0, 1'b1, "deriv2");
        check_out("deriv_step2", 16'd0, 1'b0, 1'b0);
        extra = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL stray_start_ignored: got %0d extra busy/done cycles want 0", extra);
        end
    endtask

    task automatic test_windup;
        logic [15:0] exp_final;
`ifdef PID_ANTIWINDUP_EN
        exp_final = 16'd60000;
`else
        exp_final = 16'd65535;
`endif
        kp = 16'h0A00; ki = 16'h0100; kd = 16'h0000;
        setpoint = 16'd60000; data_in = 16'd0;
        for (int i = 0; i < 4; i++) begin
            run_step(i == 0, 1'b0, "windup");
            check_out($sformatf("windup_step%0d", i), 16'd65535, 1'b1, 1'b0);
        end
        setpoint = 16'd1000; data_in = 16'd1000;
        run_step(1'b0, 1'b0, "windup_rel");
        check_out("windup_integ", exp_final, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; start = 1'b0; clear = 1'b0;
        setpoint = '0; data_in = '0; kp = '0; ki = '0; kd = '0;
        test_reset();
        test_proportional();
        test_reset_mid();
        test_saturation();
        test_integral();
        test_derivative();
        test_windup();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
